// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan controller.
// Glyphs are active-low {g,f,e,d,c,b,a}; anodes are active-low, one bit per digit.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] ANODES_OFF = 8'hFF;

    // Index 0 is the rightmost entry.
    localparam logic [15:0][6:0] FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [7:0] anode_mask(input logic lit, input logic [2:0] k);
        return lit ? ~(8'd1 << k) : ANODES_OFF;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: digit data in, display drive out.
// The controller sits on the slave side; the host driving the data uses master.
interface seg7_scan_ctrl_if #(parameter int N_DIGITS = 4);

    logic                    en;
    logic [4*N_DIGITS-1:0]   digits;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    lzb;
    logic [3:0]              bright;
    logic [N_DIGITS-1:0]     an;
    logic [6:0]              seg;
    logic                    dp;
    logic [2:0]              digit_idx;
    logic                    frame_tick;

    modport master (
        output en, digits, dp_in, lzb, bright,
        input  an, seg, dp, digit_idx, frame_tick
    );

    modport slave (
        input  en, digits, dp_in, lzb, bright,
        output an, seg, dp, digit_idx, frame_tick
    );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: hex nibble to active-low seven-segment glyph.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = FONT[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed scan of an N-digit common-anode display with
// inter-digit blanking, PWM brightness, leading-zero blanking and per-frame snapshot.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE_W   = 18,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic            CLK,
    input  logic            reset_n,
    seg7_scan_ctrl_if.slave bus
);

    localparam logic [PRESCALE_W-1:0] CNT_MAX = '1;
    localparam logic [PRESCALE_W-1:0] BLANK   = PRESCALE_W'(BLANK_CYCLES);
    localparam logic [2:0]            LAST    = 3'(N_DIGITS - 1);

    logic [PRESCALE_W-1:0] cnt;
    logic [2:0]            idx;
    logic                  en_q;
    logic [4*N_DIGITS-1:0] digits_s;
    logic [N_DIGITS-1:0]   dp_s;
    logic                  lzb_s;
    logic [3:0]            bright_s;
    logic                  frame_end;
    logic                  lit;
    logic                  zero_run;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [3:0]            cur_nib;
    logic [6:0]            glyph;

    assign frame_end = cnt == CNT_MAX && idx == LAST;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            idx  <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= bus.en;
            cnt  <= bus.en ? cnt + 1'b1 : '0;
            idx  <= !bus.en ? '0 : cnt != CNT_MAX ? idx : idx == LAST ? '0 : idx + 3'd1;
        end
    end

    // Inputs are only sampled at a frame boundary, or continuously while idle.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            digits_s <= '0;
            dp_s     <= '0;
            lzb_s    <= 1'b0;
            bright_s <= '0;
        end else if (!bus.en || frame_end) begin
            digits_s <= bus.digits;
            dp_s     <= bus.dp_in;
            lzb_s    <= bus.lzb;
            bright_s <= bus.bright;
        end
    end

    // Walk from the leftmost digit down so zero_run means "this and all higher digits are 0".
    always_comb begin
        zero_run  = 1'b1;
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && digits_s[4*k +: 4] == 4'd0;
            if (idx == 3'(k)) begin
                cur_nib   = digits_s[4*k +: 4];
                cur_dp    = dp_s[k];
                cur_blank = lzb_s && k != 0 && zero_run;
            end
        end
    end

    assign lit = bus.en && cnt >= BLANK && bright_s != 4'd0
              && cnt[PRESCALE_W-1 -: 4] < bright_s && !cur_blank;

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (glyph)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            bus.an         <= N_DIGITS'(ANODES_OFF);
            bus.seg        <= SEG_OFF;
            bus.dp         <= 1'b1;
            bus.digit_idx  <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.an         <= N_DIGITS'(anode_mask(lit, idx));
            bus.seg        <= lit ? glyph : SEG_OFF;
            bus.dp         <= ~(lit && cur_dp);
            bus.digit_idx  <= idx;
            bus.frame_tick <= bus.en && (frame_end || !en_q);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scan order, blanking, snapshot, LZB, PWM, en and reset.
// pos counts clock edges since scanning started; outputs at pos p reflect slot state p.
module tb_seg7_scan_ctrl;

    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pos = 0;

    seg7_scan_ctrl_if #(.N_DIGITS(4)) bus();

    seg7_scan_ctrl #(.N_DIGITS(4), .PRESCALE_W(6), .BLANK_CYCLES(4)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int p);
        while (pos < p) begin
            @(negedge CLK);
            pos++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lit_n, early_on, multi, ticks, changes;
        logic [2:0] prev;
        bus.en = 1'b0;
        bus.digits = 16'h1234;
        bus.dp_in = 4'b0101;
        bus.lzb = 1'b0;
        bus.bright = 4'd15;
        repeat (2) @(negedge CLK);
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'h1);
        chk("rst_ft", 32'(bus.frame_tick), 32'h0);
        chk("rst_idx", 32'(bus.digit_idx), 32'h0);
        reset_n = 1'b1;
        @(negedge CLK);
        bus.en = 1'b1;
        pos = -1;
        goto(0);
        chk("f0_ft", 32'(bus.frame_tick), 32'h1);
        chk("f0_an_c0", 32'(bus.an), 32'hF);
        goto(1);
        chk("f0_ft_off", 32'(bus.frame_tick), 32'h0);
        goto(3);
        chk("f0_an_c3", 32'(bus.an), 32'hF);
        goto(4);
        chk("f0_an_c4", 32'(bus.an), 32'hE);
        chk("f0_seg_4", 32'(bus.seg), 32'h19);
        chk("f0_dp0", 32'(bus.dp), 32'h0);
        chk("f0_idx0", 32'(bus.digit_idx), 32'h0);
        goto(59);
        chk("f0_an_c59", 32'(bus.an), 32'hE);
        goto(60);
        chk("f0_an_c60", 32'(bus.an), 32'hF);
        goto(64);
        chk("f0_idx1", 32'(bus.digit_idx), 32'h1);
        chk("f0_an_s1c0", 32'(bus.an), 32'hF);
        goto(68);
        chk("f0_an_s1", 32'(bus.an), 32'hD);
        chk("f0_seg_3", 32'(bus.seg), 32'h30);
        chk("f0_dp1", 32'(bus.dp), 32'h1);
        goto(132);
        chk("f0_an_s2", 32'(bus.an), 32'hB);
        chk("f0_seg_2", 32'(bus.seg), 32'h24);
        goto(160);
        bus.digits = 16'h5678;
        goto(196);
        chk("snap_an_s3", 32'(bus.an), 32'h7);
        chk("snap_seg_1", 32'(bus.seg), 32'h79);
        goto(255);
        chk("f1_ft", 32'(bus.frame_tick), 32'h1);
        goto(256);
        chk("f1_ft_off", 32'(bus.frame_tick), 32'h0);
        goto(260);
        chk("f1_seg_8", 32'(bus.seg), 32'h00);
        goto(324);
        chk("f1_seg_7", 32'(bus.seg), 32'h78);
        goto(388);
        chk("f1_seg_6", 32'(bus.seg), 32'h02);
        goto(452);
        chk("f1_an_s3", 32'(bus.an), 32'h7);
        chk("f1_seg_5", 32'(bus.seg), 32'h12);
        lit_n = 0;
        early_on = 0;
        multi = 0;
        ticks = 0;
        changes = 0;
        goto(511);
        prev = bus.digit_idx;
        for (int p = 512; p < 768; p++) begin
            goto(p);
            if (bus.an != 4'hF) lit_n++;
            if ($countones(~bus.an) > 1) multi++;
            if (p % 64 < 4 && bus.an != 4'hF) early_on++;
            if (bus.frame_tick) ticks++;
            if (bus.digit_idx != prev) changes++;
            prev = bus.digit_idx;
            if (p == 600) begin
                bus.lzb = 1'b1;
                bus.digits = 16'h0050;
            end
        end
        chk("f2_lit_cycles", 32'(lit_n), 32'd224);
        chk("f2_multi_low", 32'(multi), 32'd0);
        chk("f2_early_on", 32'(early_on), 32'd0);
        chk("f2_ticks", 32'(ticks), 32'd1);
        chk("f2_idx_changes", 32'(changes), 32'd4);
        goto(772);
        chk("lzb_an_s0", 32'(bus.an), 32'hE);
        chk("lzb_seg_0", 32'(bus.seg), 32'h40);
        goto(836);
        chk("lzb_an_s1", 32'(bus.an), 32'hD);
        chk("lzb_seg_5", 32'(bus.seg), 32'h12);
        goto(900);
        chk("lzb_an_s2", 32'(bus.an), 32'hF);
        chk("lzb_seg_s2", 32'(bus.seg), 32'h7F);
        chk("lzb_idx2", 32'(bus.digit_idx), 32'h2);
        goto(964);
        chk("lzb_an_s3", 32'(bus.an), 32'hF);
        goto(970);
        bus.digits = 16'h0000;
        goto(1028);
        chk("lzb0_an_s0", 32'(bus.an), 32'hE);
        chk("lzb0_seg_0", 32'(bus.seg), 32'h40);
        goto(1092);
        chk("lzb0_an_s1", 32'(bus.an), 32'hF);
        goto(1100);
        bus.lzb = 1'b0;
        bus.digits = 16'h1234;
        bus.bright = 4'd8;
        goto(1284);
        chk("b8_an_c4", 32'(bus.an), 32'hE);
        goto(1311);
        chk("b8_an_c31", 32'(bus.an), 32'hE);
        goto(1312);
        chk("b8_an_c32", 32'(bus.an), 32'hF);
        goto(1320);
        bus.bright = 4'd0;
        goto(1540);
        chk("b0_an_s0", 32'(bus.an), 32'hF);
        goto(1560);
        chk("b0_an_s0b", 32'(bus.an), 32'hF);
        goto(1570);
        bus.bright = 4'd15;
        goto(1604);
        chk("b0_an_s1", 32'(bus.an), 32'hF);
        goto(1930);
        chk("f7_an_s2", 32'(bus.an), 32'hB);
        chk("f7_seg_2", 32'(bus.seg), 32'h24);
        chk("f7_dp2", 32'(bus.dp), 32'h0);
        bus.en = 1'b0;
        goto(1931);
        chk("en0_an", 32'(bus.an), 32'hF);
        chk("en0_ft", 32'(bus.frame_tick), 32'h0);
        goto(1932);
        chk("en0_idx", 32'(bus.digit_idx), 32'h0);
        chk("en0_an2", 32'(bus.an), 32'hF);
        bus.en = 1'b1;
        pos = -1;
        goto(0);
        chk("en1_ft", 32'(bus.frame_tick), 32'h1);
        chk("en1_idx", 32'(bus.digit_idx), 32'h0);
        goto(1);
        chk("en1_ft_off", 32'(bus.frame_tick), 32'h0);
        goto(4);
        chk("en1_an", 32'(bus.an), 32'hE);
        chk("en1_seg", 32'(bus.seg), 32'h19);
        goto(10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_an", 32'(bus.an), 32'hF);
        chk("arst_seg", 32'(bus.seg), 32'h7F);
        chk("arst_dp", 32'(bus.dp), 32'h1);
        chk("arst_idx", 32'(bus.digit_idx), 32'h0);
        @(negedge CLK);
        reset_n = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
